// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / uart_tx handshake bundle shared by the TX arbiter and its neighbours.
// The slave side is the arbiter; the master side drives the sources and the uart_tx pull.
interface uart_tx_arbiter_if #(
    parameter int N = 2,
    parameter int W = 8
);
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_empty;
    logic [N-1:0]   src_get;
    logic [W-1:0]   out;
    logic           get;
    logic           empty;
    logic [N-1:0]   grant;
    logic           locked;

    modport slave (
        input  src_data, src_empty, get,
        output src_get, out, empty, grant, locked
    );

    modport master (
        output src_data, src_empty, get,
        input  src_get, out, empty, grant, locked
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with line lock in front of uart_tx: an owner keeps the
// transmitter until its EOL byte is taken or it stays empty for IDLE_LIMIT clocks.
module uart_tx_arbiter #(
    parameter int             N          = 2,
    parameter int             W          = 8,
    parameter logic [W-1:0]   EOL        = 8'h0A,
    parameter int             IDLE_LIMIT = 16
) (
    input  logic               clock,
    input  logic               reset,
    uart_tx_arbiter_if.slave   bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(IDLE_LIMIT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]    r_state;
    logic [N-1:0]  r_grant;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;

    logic          w_locked;
    logic [W-1:0]  w_own_data;
    logic          w_own_empty;
    logic          w_take;
    logic          w_eol;
    logic          w_timeout;
    logic          w_release;
    logic          w_found;
    logic [PW-1:0] w_pick;
    logic [PW-1:0] w_idx;

    assign w_locked    = (r_state == S_LOCK);
    assign w_own_data  = bus.src_data[r_owner*W +: W];
    assign w_own_empty = bus.src_empty[r_owner];
    assign w_take      = w_locked & bus.get & ~w_own_empty;
    assign w_eol       = w_take && (w_own_data == EOL);
    // Release fires on the clock that would bring the empty count up to IDLE_LIMIT.
    assign w_timeout   = w_locked && w_own_empty && (r_cnt == CW'(IDLE_LIMIT - 1));
    assign w_release   = w_eol | w_timeout;

    // The owner drives the sink directly; r_grant is zero outside LOCK, which gates src_get.
    assign bus.out     = w_locked ? w_own_data : '0;
    assign bus.empty   = w_locked ? w_own_empty : 1'b1;
    assign bus.src_get = r_grant & {N{w_take}};
    assign bus.grant   = r_grant;
    assign bus.locked  = w_locked;

    // Search starts just after the last owner, so that owner is considered last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= N; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N);
            if (!w_found && !bus.src_empty[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= PW'(N - 1);
            r_cnt   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_found) begin
                r_state <= S_LOCK;
                r_grant <= N'(1) << w_pick;
                r_owner <= w_pick;
                r_cnt   <= '0;
            end
        end else if (w_release) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= r_owner;
            r_cnt   <= '0;
        end else if (!w_own_empty) begin
            r_cnt <= '0;
        end else if (r_cnt != CW'(IDLE_LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for two-source round robin
// plus hand sequences for idle, full-line pull, timeout, ignored get and async reset.
module tb_uart_tx_arbiter;
    localparam int N = 2;
    localparam int W = 8;

    typedef struct {
        logic        get;
        logic [13:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.N(N), .W(W)) bus ();

    uart_tx_arbiter #(
        .N(N), .W(W), .EOL(8'h0A), .IDLE_LIMIT(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit en0 = 1'b0;
    bit en1 = 1'b0;

    // Snapshot layout: {out[7:0], empty, grant[1:0], src_get[1:0], locked}
    function automatic logic [13:0] e(logic [7:0] o, logic emp, logic [1:0] gr,
                                      logic [1:0] sg, logic lk);
        return {o, emp, gr, sg, lk};
    endfunction

    function automatic logic [13:0] snap();
        return {bus.out, bus.empty, bus.grant, bus.src_get, bus.locked};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        bus.src_empty[0]  = !(en0 && q0.size() > 0);
        bus.src_empty[1]  = !(en1 && q1.size() > 0);
        bus.src_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.src_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    // Advance one clock; sources pop whatever src_get strobed before the edge.
    task automatic step();
        logic [N-1:0] g;
        #1;
        g = bus.src_get;
        @(posedge clock);
        #1;
        if (g[0]) void'(q0.pop_front());
        if (g[1]) void'(q1.pop_front());
        refresh();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    vec_t tbl[10];
    logic [7:0] hello[7];

    initial begin
        int bad;
        int npulse;
        int extra;
        bit seen_idle;

        tbl[0] = '{1'b1, e(8'h00, 1'b1, 2'b00, 2'b00, 1'b0)};
        tbl[1] = '{1'b1, e(8'h41, 1'b0, 2'b01, 2'b01, 1'b1)};
        tbl[2] = '{1'b0, e(8'h42, 1'b0, 2'b01, 2'b00, 1'b1)};
        tbl[3] = '{1'b1, e(8'h42, 1'b0, 2'b01, 2'b01, 1'b1)};
        tbl[4] = '{1'b1, e(8'h0A, 1'b0, 2'b01, 2'b01, 1'b1)};
        tbl[5] = '{1'b1, e(8'h00, 1'b1, 2'b00, 2'b00, 1'b0)};
        tbl[6] = '{1'b1, e(8'h78, 1'b0, 2'b10, 2'b10, 1'b1)};
        tbl[7] = '{1'b1, e(8'h79, 1'b0, 2'b10, 2'b10, 1'b1)};
        tbl[8] = '{1'b1, e(8'h0A, 1'b0, 2'b10, 2'b10, 1'b1)};
        tbl[9] = '{1'b1, e(8'h00, 1'b1, 2'b00, 2'b00, 1'b0)};
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

        bus.get = 1'b0;
        refresh();

        // All sources empty for 50 clocks
        do_reset();
        #1;
        chk("reset_state", 32'(snap()), 32'(e(8'h00, 1'b1, 2'b00, 2'b00, 1'b0)));
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            bus.get = k[0];
            #1;
            if (bus.grant !== 2'b00 || bus.empty !== 1'b1 || bus.src_get !== 2'b00) bad++;
            step();
        end
        chk("idle_50_violations", 32'(bad), 32'd0);

        // Source 0 alone with "Hello\r\n", uart_tx pulling two of every three clocks
        q0 = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
        en0 = 1'b1;
        refresh();
        do_reset();
        #1;
        chk("hello_pre_grant", 32'(bus.grant), 32'(2'b00));
        step();
        chk("hello_grant", 32'({bus.grant, bus.locked}), 32'({2'b01, 1'b1}));
        npulse = 0;
        seen_idle = 1'b0;
        for (int k = 0; k < 30 && !seen_idle; k++) begin
            bus.get = (k % 3 != 2);
            #1;
            if (bus.src_get[1] !== 1'b0) chk("hello_src1_get", 32'(bus.src_get), 32'(2'b01));
            if (bus.src_get[0] === 1'b1) begin
                if (npulse < 7) chk("hello_byte", 32'(bus.out), 32'(hello[npulse]));
                npulse++;
            end
            step();
            if (npulse == 7) begin
                chk("hello_release", 32'({bus.grant, bus.locked, bus.empty}),
                    32'({2'b00, 1'b0, 1'b1}));
                seen_idle = 1'b1;
            end
        end
        chk("hello_pulses", 32'(npulse), 32'd7);
        extra = 0;
        bus.get = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.src_get !== 2'b00) extra++;
            step();
        end
        chk("hello_no_extra", 32'(extra), 32'd0);

        // Both sources ready from reset: table-driven round robin
        q0 = '{8'h41, 8'h42, 8'h0A};
        q1 = '{8'h78, 8'h79, 8'h0A};
        en0 = 1'b1;
        en1 = 1'b1;
        refresh();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.get = tbl[i].get;
            #1;
            chk($sformatf("rr_vec%0d", i), 32'(snap()), 32'(tbl[i].exp));
            step();
        end

        // Source 0 stalls without EOL while source 1 waits; get pulses are ignored
        q0 = '{8'h41, 8'h42};
        q1 = '{8'h78, 8'h79, 8'h0A};
        refresh();
        do_reset();
        bus.get = 1'b1;
        step();
        chk("to_grant0", 32'(bus.grant), 32'(2'b01));
        #1;
        chk("to_byte41", 32'({bus.out, bus.src_get}), 32'({8'h41, 2'b01}));
        step();
        chk("to_byte42", 32'({bus.out, bus.src_get}), 32'({8'h42, 2'b01}));
        step();
        for (int k = 1; k <= 16; k++) begin
            bus.get = (k == 2 || k == 5 || k == 8);
            #1;
            chk($sformatf("to_noget%0d", k), 32'({bus.src_get, bus.empty}), 32'({2'b00, 1'b1}));
            step();
            if (k < 16)
                chk($sformatf("to_held%0d", k), 32'({bus.grant, bus.locked}), 32'({2'b01, 1'b1}));
            else
                chk("to_release", 32'({bus.grant, bus.locked}), 32'({2'b00, 1'b0}));
        end
        bus.get = 1'b0;
        step();
        chk("to_grant1", 32'({bus.grant, bus.locked}), 32'({2'b10, 1'b1}));

        // Asynchronous reset in the middle of source 1's line
        bus.get = 1'b1;
        #1;
        chk("mid_byte78", 32'({bus.out, bus.src_get}), 32'({8'h78, 2'b10}));
        step();
        chk("mid_byte79", 32'({bus.out, bus.src_get}), 32'({8'h79, 2'b10}));
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_outputs", 32'(snap()), 32'(e(8'h00, 1'b1, 2'b00, 2'b00, 1'b0)));
        q0 = '{8'h51, 8'h0A};
        refresh();
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("post_reset_idle", 32'(snap()), 32'(e(8'h00, 1'b1, 2'b00, 2'b00, 1'b0)));
        step();
        chk("post_reset_grant0", 32'({bus.grant, bus.out}), 32'({2'b01, 8'h51}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx byte sink between N pull-style byte sources, such as the hello ROM and the RX loopback FIFO. Arbitration is round-robin with line lock: a granted source keeps the transmitter until it emits the end-of-line byte or stays empty past a timeout. This prevents lines from different sources interleaving on the wire. It replaces the hand-built empty-priority mux in front of uart_tx.

Parameters:
N, 2, number of requesting sources (2..8)
W, 8, byte width
EOL, 8'h0A, terminator byte that releases the lock after it is transferred
IDLE_LIMIT, 16, consecutive empty clocks tolerated while locked before forced release (1..255)

Ports:
clock  in  1  arbiter/TX clock (uart_clock domain); all state on posedge
reset  in  1  asynchronous, active-high
src_data  in  N*W  byte from source i at bits [i*W +: W]
src_empty  in  N  source i has no byte
src_get  out  N  one-clock take strobe to source i
out  out  W  byte presented to uart_tx
get  in  1  one-clock take strobe from uart_tx
empty  out  1  no byte available to uart_tx
grant  out  N  one-hot owner; all-zero when idle
locked  out  1  high in LOCK state

Behaviour:
- Async reset values: state IDLE, grant=0, locked=0, empty=1, src_get=0, out=0, idle counter=0, rr pointer=N-1, so source 0 wins the first contest.
- IDLE state:
  - empty=1, out=0, src_get=0.
  - If any src_empty[i]==0 at a posedge, grant the first non-empty source searching from pointer+1 modulo N.
  - Grant, locked=1 and LOCK state are registered. Request-to-grant latency is 1 clock.
- LOCK state (owner g):
  - out=src_data[g] and empty=src_empty[g], combinational from the owner.
  - src_get[g]=get & ~src_empty[g]; every other src_get bit is 0.
  - get while empty=1 is ignored: no strobe is forwarded and no state changes.
- EOL release: on a clock where get is accepted and src_data[g]==EOL:
  - next state IDLE, grant=0, pointer=g, counter=0.
  - The EOL byte itself is delivered to the owner's consumer.
- Timeout release:
  - Counter clears on any clock where src_empty[g]==0.
  - It increments on each clock where src_empty[g]==1.
  - When it reaches IDLE_LIMIT, release as for EOL at that posedge.
- Back-to-back ownership:
  - A source is re-evaluated in IDLE only. The minimum gap between owners is one IDLE clock (empty=1).
  - A source that was just released is lowest priority in the next contest. It is regranted only if no other source is non-empty.
- Other sources' requests during LOCK are ignored; there is no preemption.
- Counter width is $clog2(IDLE_LIMIT+1) and the counter saturates; no wrap.
- Reset asserted mid-line:
  - all outputs return to reset values immediately; src_get is gated by locked.
  - The partial line is abandoned; the source is not rewound.
- Sources must hold src_data stable while non-empty. The arbiter does not register data.

Test Plan:
- Reset, then hold all src_empty=1 for 50 clocks -> grant=0, empty=1, src_get never asserts.
- Source 0 only, holding "Hello\r\n" (48 65 6C 6C 6F 0D 0A); uart_tx pulls bytes -> grant=01 one clock after request, 7 bytes appear on out in order, src_get[0] pulses exactly 7 times, IDLE on the clock after the 0x0A get.
- Both sources non-empty from reset (src0 "AB\n", src1 "xy\n") -> sequence 41 42 0A 78 79 0A on out; grant 01, then 00 for one clock, then 10; no interleaving; src_get[1] stays 0 during source 0's line.
- Source 0 sends 41 42, then stays empty with no EOL while source 1 is non-empty -> locked persists 15 empty clocks, releases on the 16th, and grant=10 on the next clock.
- While locked and src_empty[g]=1, pulse get 3 times -> no src_get pulses, no state change, counter unaffected by get.
- Assert reset asynchronously between edges mid-line during source 1's line -> grant=0, empty=1, src_get=0 immediately; after release, source 0 wins the first contest.
